// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and helpers for the BCD counter and the downstream
// BCD-to-Gray converter checks.
package bcd_updown_counter_pkg;

    localparam int          BCD_W   = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

    function automatic logic is_bcd(input logic [BCD_W-1:0] digit);
        return digit <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_if.sv
// Request/response bundle of the BCD counter: step/load controls in,
// registered count with valid/ready handshake and status pulses out.
interface bcd_updown_counter_if #(
    parameter int NDIGITS = 2
);
    import bcd_updown_counter_pkg::*;

    logic                       en;
    logic                       up;
    logic                       load;
    logic [BCD_W*NDIGITS-1:0]   load_val;
    logic [BCD_W*NDIGITS-1:0]   bcd;
    logic                       out_valid;
    logic                       out_ready;
    logic                       tc;
    logic                       err;

    modport master (
        input  en, up, load, load_val, out_ready,
        output bcd, out_valid, tc, err
    );

    modport slave (
        output en, up, load, load_val, out_ready,
        input  bcd, out_valid, tc, err
    );

endinterface

// File: rtl/bcd_updown_counter_digit.sv
// One BCD digit of the ripple chain: applies carry (up) or borrow (down)
// and reports wrap-around to the next digit. Purely combinational.
module bcd_digit
    import bcd_updown_counter_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             up,
    input  logic             cin,
    output logic [BCD_W-1:0] next_digit,
    output logic             cout
);

    always_comb begin
        next_digit = digit;
        cout       = 1'b0;
        if (cin) begin
            if (up) begin
                if (digit >= BCD_MAX) begin
                    next_digit = '0;
                    cout       = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == '0) begin
                    next_digit = BCD_MAX;
                    cout       = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with parallel load, registered output
// under valid/ready backpressure, and terminal-count / load-error pulses.
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int NDIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    bcd_updown_counter_if.master  bus
);

    localparam int W = BCD_W * NDIGITS;

    logic [W-1:0]     bcd_q;
    logic [W-1:0]     bcd_step;
    logic [NDIGITS:0] carry;
    logic             valid_q;
    logic             tc_q;
    logic             err_q;
    logic             stall;
    logic             load_ok;

    assign stall    = valid_q && !bus.out_ready;
    assign carry[0] = 1'b1;

    for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .digit      (bcd_q[g*BCD_W +: BCD_W]),
            .up         (bus.up),
            .cin        (carry[g]),
            .next_digit (bcd_step[g*BCD_W +: BCD_W]),
            .cout       (carry[g+1])
        );
    end

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < NDIGITS; i++) begin
            if (!is_bcd(bus.load_val[i*BCD_W +: BCD_W])) load_ok = 1'b0;
        end
    end

    // Without a stall, any value still marked valid is being accepted this
    // edge, so clearing valid_q on non-updating branches drops only consumed data.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bcd_q   <= '0;
            valid_q <= 1'b0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end else if (stall) begin
            tc_q  <= 1'b0;
            err_q <= 1'b0;
        end else if (bus.load) begin
            tc_q <= 1'b0;
            if (load_ok) begin
                bcd_q   <= bus.load_val;
                valid_q <= 1'b1;
                err_q   <= 1'b0;
            end else begin
                valid_q <= 1'b0;
                err_q   <= 1'b1;
            end
        end else if (bus.en) begin
            bcd_q   <= bcd_step;
            valid_q <= 1'b1;
            tc_q    <= carry[NDIGITS];
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            tc_q    <= 1'b0;
            err_q   <= 1'b0;
        end
    end

    assign bus.bcd       = bcd_q;
    assign bus.out_valid = valid_q;
    assign bus.tc        = tc_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed bench for bcd_updown_counter (NDIGITS=2); each driven cycle
// queues its expected post-edge outputs, a monitor pops and compares them.
module tb_bcd_updown_counter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   cyc_no;

    typedef struct {
        logic [7:0] b;
        logic       v;
        logic       t;
        logic       e;
    } exp_t;

    exp_t sb[$];

    bcd_updown_counter_if #(.NDIGITS(2)) bus ();

    bcd_updown_counter #(.NDIGITS(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", nm, cyc_no, act, exp_v);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            cyc_no++;
            chk("bcd",       bus.bcd,              x.b);
            chk("out_valid", {7'd0, bus.out_valid}, {7'd0, x.v});
            chk("tc",        {7'd0, bus.tc},        {7'd0, x.t});
            chk("err",       {7'd0, bus.err},       {7'd0, x.e});
        end
    end

    task automatic cyc(input logic r, input logic e, input logic u, input logic l,
                       input logic [7:0] lv, input logic rdy,
                       input logic [7:0] xb, input logic xv, input logic xt, input logic xe);
        exp_t x;
        @(negedge clk);
        rst_n         = r;
        bus.en        = e;
        bus.up        = u;
        bus.load      = l;
        bus.load_val  = lv;
        bus.out_ready = rdy;
        x.b = xb; x.v = xv; x.t = xt; x.e = xe;
        sb.push_back(x);
    endtask

    function automatic logic [7:0] bcd8(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        cyc_no = 0;
        rst_n = 1'b0;
        bus.en = 1'b0; bus.up = 1'b0; bus.load = 1'b0;
        bus.load_val = 8'h00; bus.out_ready = 1'b1;

        // reset
        cyc(0, 0, 0, 0, 8'h00, 1, 8'h00, 0, 0, 0);
        cyc(0, 1, 1, 1, 8'h55, 1, 8'h00, 0, 0, 0);

        // count up 01..12
        for (int i = 1; i <= 12; i++) cyc(1, 1, 1, 0, 8'h00, 1, bcd8(i), 1, 0, 0);

        // up wrap
        cyc(1, 0, 1, 1, 8'h98, 1, 8'h98, 1, 0, 0);
        cyc(1, 1, 1, 0, 8'h00, 1, 8'h99, 1, 0, 0);
        cyc(1, 1, 1, 0, 8'h00, 1, 8'h00, 1, 1, 0);
        cyc(1, 1, 1, 0, 8'h00, 1, 8'h01, 1, 0, 0);

        // down wrap and inter-digit borrow
        cyc(1, 0, 0, 1, 8'h01, 1, 8'h01, 1, 0, 0);
        cyc(1, 1, 0, 0, 8'h00, 1, 8'h00, 1, 0, 0);
        cyc(1, 1, 0, 0, 8'h00, 1, 8'h99, 1, 1, 0);
        cyc(1, 1, 0, 0, 8'h00, 1, 8'h98, 1, 0, 0);
        cyc(1, 0, 0, 1, 8'h10, 1, 8'h10, 1, 0, 0);
        cyc(1, 1, 0, 0, 8'h00, 1, 8'h09, 1, 0, 0);

        // invalid loads
        cyc(1, 0, 0, 1, 8'h25, 1, 8'h25, 1, 0, 0);
        cyc(1, 1, 1, 1, 8'h3A, 1, 8'h25, 0, 0, 1);
        cyc(1, 0, 1, 0, 8'h00, 1, 8'h25, 0, 0, 0);
        cyc(1, 0, 1, 1, 8'h25, 0, 8'h25, 1, 0, 0);
        cyc(1, 0, 1, 1, 8'h3A, 0, 8'h25, 1, 0, 0);
        cyc(1, 1, 1, 1, 8'hA5, 1, 8'h25, 0, 0, 1);

        // backpressure
        cyc(1, 0, 1, 1, 8'h04, 1, 8'h04, 1, 0, 0);
        cyc(1, 1, 1, 0, 8'h00, 1, 8'h05, 1, 0, 0);
        cyc(1, 1, 1, 0, 8'h00, 0, 8'h05, 1, 0, 0);
        cyc(1, 1, 1, 0, 8'h00, 0, 8'h05, 1, 0, 0);
        cyc(1, 1, 1, 0, 8'h00, 0, 8'h05, 1, 0, 0);
        cyc(1, 1, 1, 0, 8'h00, 1, 8'h06, 1, 0, 0);
        cyc(1, 1, 1, 0, 8'h00, 1, 8'h07, 1, 0, 0);
        cyc(1, 0, 1, 0, 8'h00, 1, 8'h07, 0, 0, 0);
        cyc(1, 0, 1, 0, 8'h00, 0, 8'h07, 0, 0, 0);

        // stalled step at 99 must not wrap until accepted
        cyc(1, 0, 1, 1, 8'h99, 1, 8'h99, 1, 0, 0);
        cyc(1, 1, 1, 0, 8'h00, 0, 8'h99, 1, 0, 0);
        cyc(1, 1, 1, 0, 8'h00, 1, 8'h00, 1, 1, 0);

        // reset mid-count
        cyc(1, 1, 1, 0, 8'h00, 1, 8'h01, 1, 0, 0);
        cyc(0, 1, 1, 1, 8'h55, 1, 8'h00, 0, 0, 0);
        cyc(1, 1, 1, 0, 8'h00, 1, 8'h01, 1, 0, 0);
        cyc(1, 1, 1, 0, 8'h00, 1, 8'h02, 1, 0, 0);

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drain", 8'(sb.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
Name: bcd_updown_counter

Overview:
- Multi-digit synchronous BCD up/down counter with parallel load.
- Sits directly upstream of the BCD-to-Gray converter stage and supplies its 4-bit-per-digit BCD input.
- Registered output with valid/ready handshake, so downstream stages can apply backpressure.
- Terminal-count and load-error pulses for cascading and diagnostics.

Parameters:
- NDIGITS, 2, number of BCD digits. Count range is 0 to 10^NDIGITS-1.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- en  input  1  count-step request.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  parallel-load request; has priority over en.
- load_val  input  4*NDIGITS  load value, digit 0 in bits [3:0].
- bcd  output  4*NDIGITS  registered count, digit 0 in bits [3:0]; every digit always 0..9.
- out_valid  output  1  bcd holds a value not yet accepted by downstream.
- out_ready  input  1  downstream accepts bcd when out_valid && out_ready.
- tc  output  1  one-cycle pulse: this update wrapped (up 99..9->0, or down 0->99..9).
- err  output  1  one-cycle pulse: load rejected because a load_val digit > 9.

Behaviour:
- Reset values (rst_n=0 at an edge): bcd=0, out_valid=0, tc=0, err=0.
  - Reset mid-operation discards any pending value; no partial update.
- stall = out_valid && !out_ready. While stall=1:
  - bcd is frozen; en and load are ignored (not queued).
  - tc=0 and err=0.
- Priority at each edge when stall=0: reset > load > en > idle.
- Load with all digits <= 9: bcd<=load_val, out_valid<=1, tc<=0, err<=0.
- Load with any digit > 9: bcd unchanged, err<=1 for one cycle, tc<=0.
  - out_valid<=0 if the current value is accepted this edge; otherwise it is unchanged.
- Step (en=1, load=0):
  - Up: digit 0 +1. A digit at 9 wraps to 0 and carries into the next digit.
  - Down: digit 0 -1. A digit at 0 wraps to 9 and borrows from the next digit.
  - Ripple carry/borrow across all NDIGITS digits in one cycle (combinational).
  - out_valid<=1.
  - tc<=1 only when the carry/borrow leaves the top digit, e.g. 99->00 up or 00->99 down (NDIGITS=2). Otherwise tc<=0.
- Idle (en=0, load=0): bcd held; tc<=0; err<=0.
  - out_valid<=0 if the value is accepted this edge; otherwise unchanged.
- Latency: one cycle from request edge to new bcd/out_valid. Full throughput (one update per cycle) when out_ready=1.
- Accept and update on the same edge: the old value is consumed, the new value is presented, and out_valid stays 1.
- up changes take effect on the next step; there is no direction-change penalty.

Decomposition:
- Shared package:
  - BCD_W = 4
  - BCD_MAX = 4'd9
  - function is_bcd(digit) returning digit <= 9, reused by the converter checks.
- Sub-module bcd_digit, instantiated NDIGITS times in a generate loop:
  - Inputs: digit value, up, cin (carry/borrow in).
  - Outputs: next digit, cout.
  - Purely combinational; all registers live in the top.

Test Plan:
1. Reset, then en=1, up=1, out_ready=1 for 12 cycles (NDIGITS=2) -> bcd 00,01..09,10,11,12 on successive cycles; out_valid=1 from the first step; tc=0 throughout.
2. load=1, load_val=8'h98, then up-steps -> bcd 98, 99, 00 with tc=1 only on the cycle bcd=00, then 01 with tc=0.
3. load_val=8'h01, then down-steps -> bcd 01, 00, 99 with tc=1 on the 99 cycle, then 98; also confirm 10 -> 09 borrow.
4. load=1, load_val=8'h3A -> err=1 for one cycle, bcd unchanged (e.g. stays 25), tc=0. Repeat with out_valid=1 and out_ready=0 -> err=0, no change (stalled).
5. Backpressure: count to 05, hold out_ready=0 for 3 cycles with en=1 -> bcd stays 05, out_valid=1. Raise out_ready -> next edge bcd=06, then 07 each cycle.
6. Mid-count, drive rst_n=0 for one edge with en=1 and load=1 -> bcd=00, out_valid=0, tc=0, err=0 on that edge. Counting resumes from 00->01 after rst_n=1.
